// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory req/ack port and decode valid/ready port.
interface if_fetch_if;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        id_valid;
   logic [15:0] id_instr;
   logic [15:0] id_pc;
   logic        id_ready;

   modport master (
      input  redirect, redirect_pc, imem_ack, imem_rdata, id_ready,
      output imem_req, imem_addr, id_valid, id_instr, id_pc
   );

   modport slave (
      output redirect, redirect_pc, imem_ack, imem_rdata, id_ready,
      input  imem_req, imem_addr, id_valid, id_instr, id_pc
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC sequencing, imem req/ack handshake with drain of abandoned
// requests on redirect, and a 2-entry instruction queue toward decode.
module if_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input logic      clk,
   input logic      rst,
   if_fetch_if.master bus
);
   localparam int unsigned W = 16;

   typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

   state_t         state, state_nx;
   logic [W-1:0]   fetch_pc, pc_nx;
   logic [W-1:0]   target, tgt_nx;
   logic [1:0]     count, count_nx;
   logic [W-1:0]   q_pc    [2];
   logic [W-1:0]   q_instr [2];
   logic           push, pop, pending, wr_idx;
   logic           req_nx;
   logic [W-1:0]   addr_nx;

   assign pending = bus.imem_req && !bus.imem_ack;
   assign push    = (state == RUN) && bus.imem_req && bus.imem_ack && !bus.redirect;
   assign pop     = (count != 2'd0) && bus.id_ready && !bus.redirect;
   assign wr_idx  = (count == 2'd1) && !pop;

   assign bus.id_instr = q_instr[0];
   assign bus.id_pc    = q_pc[0];

   // Queue occupancy; redirect flushes regardless of push/pop
   always_comb begin
      count_nx = count;
      if (bus.redirect)       count_nx = 2'd0;
      else if (push && !pop)  count_nx = count + 2'd1;
      else if (pop && !push)  count_nx = count - 2'd1;
   end

   // Next state, PC and request; an un-acked request is never withdrawn
   always_comb begin
      state_nx = state;
      pc_nx    = fetch_pc;
      tgt_nx   = target;
      case (state)
         BOOT: begin
            state_nx = RUN;
            if (bus.redirect) pc_nx = bus.redirect_pc;
         end
         RUN: begin
            if (bus.redirect) begin
               if (pending) begin
                  state_nx = DRAIN;
                  tgt_nx   = bus.redirect_pc;
               end else begin
                  pc_nx = bus.redirect_pc;
               end
            end else if (push) begin
               pc_nx = fetch_pc + W'(1);
            end
         end
         DRAIN: begin
            if (bus.redirect) tgt_nx = bus.redirect_pc;
            if (bus.imem_ack) begin
               state_nx = RUN;
               pc_nx    = tgt_nx;
            end
         end
         default: state_nx = BOOT;
      endcase
      req_nx  = (state_nx == DRAIN) || ((state_nx == RUN) && (count_nx != 2'd2));
      addr_nx = (state_nx == DRAIN) ? bus.imem_addr : pc_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= BOOT;
         fetch_pc      <= RESET_PC;
         target        <= RESET_PC;
         count         <= 2'd0;
         bus.imem_req  <= 1'b0;
         bus.imem_addr <= RESET_PC;
         bus.id_valid  <= 1'b0;
         q_pc[0]       <= '0;
         q_pc[1]       <= '0;
         q_instr[0]    <= '0;
         q_instr[1]    <= '0;
      end else begin
         state         <= state_nx;
         fetch_pc      <= pc_nx;
         target        <= tgt_nx;
         count         <= count_nx;
         bus.imem_req  <= req_nx;
         bus.imem_addr <= addr_nx;
         bus.id_valid  <= (count_nx != 2'd0);
         // Shift on pop first, then a push lands in the first free slot
         if (pop) begin
            q_pc[0]    <= q_pc[1];
            q_instr[0] <= q_instr[1];
         end
         if (push) begin
            if (wr_idx) begin
               q_pc[1]    <= fetch_pc;
               q_instr[1] <= bus.imem_rdata;
            end else begin
               q_pc[0]    <= fetch_pc;
               q_instr[0] <= bus.imem_rdata;
            end
         end
      end
   end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed phases push expected PCs, a negedge monitor
// checks every decode handshake and the imem request stability.
module tb_if_fetch_unit;
   localparam logic [15:0] XOR_KEY = 16'hA5C3;

   logic        clk = 1'b0;
   logic        rst;
   logic        ack, ready, redir;
   logic [15:0] redir_pc;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] exp_q [$];
   logic        prev_pend = 1'b0;
   logic [15:0] prev_addr = 16'h0;

   if_fetch_if bus ();

   assign bus.redirect    = redir;
   assign bus.redirect_pc = redir_pc;
   assign bus.imem_ack    = ack;
   assign bus.id_ready    = ready;
   assign bus.imem_rdata  = bus.imem_addr ^ XOR_KEY;

   if_fetch_unit #(.RESET_PC(16'h0010)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic expect_pc(input logic [15:0] pc);
      exp_q.push_back(pc);
   endtask

   // Monitor: decode handshakes against scoreboard, and no early withdrawal of a request
   always @(negedge clk) begin
      if (rst) begin
         prev_pend <= 1'b0;
      end else begin
         if (prev_pend) begin
            check("req_held", 16'(bus.imem_req), 16'h1);
            check("addr_held", bus.imem_addr, prev_addr);
         end
         prev_pend <= bus.imem_req && !ack;
         prev_addr <= bus.imem_addr;
         if (bus.id_valid && ready && !redir) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_delivery: got pc %h with nothing expected", bus.id_pc);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               check("deliv_pc", bus.id_pc, e);
               check("deliv_instr", bus.id_instr, e ^ XOR_KEY);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; ack = 1'b1; ready = 1'b1; redir = 1'b0; redir_pc = 16'h0;
      // Phase A deliveries: boot, redirect idle, redirect during wait, wrap
      expect_pc(16'h0010); expect_pc(16'h0011); expect_pc(16'h0100);
      expect_pc(16'h0300); expect_pc(16'hFFFE); expect_pc(16'hFFFF);
      repeat (3) @(posedge clk);
      #1;
      mid();
      check("rst_req", 16'(bus.imem_req), 16'h0);
      check("rst_valid", 16'(bus.id_valid), 16'h0);
      check("rst_addr", bus.imem_addr, 16'h0010);
      check("rst_instr", bus.id_instr, 16'h0000);
      check("rst_idpc", bus.id_pc, 16'h0000);

      nxt(); rst = 1'b0;                        // cycle 0 (BOOT)
      mid(); check("boot_req", 16'(bus.imem_req), 16'h0);
      nxt(); mid();                             // cycle 1
      check("c1_req", 16'(bus.imem_req), 16'h1);
      check("c1_addr", bus.imem_addr, 16'h0010);
      check("c1_valid", 16'(bus.id_valid), 16'h0);
      nxt(); mid();                             // cycle 2
      check("c2_addr", bus.imem_addr, 16'h0011);
      check("c2_valid", 16'(bus.id_valid), 16'h1);
      check("c2_idpc", bus.id_pc, 16'h0010);
      nxt(); mid();                             // cycle 3
      check("c3_addr", bus.imem_addr, 16'h0012);
      check("c3_idpc", bus.id_pc, 16'h0011);
      nxt(); ready = 1'b0;                      // cycle 4
      nxt(); mid();                             // cycle 5: queue full
      check("full_req", 16'(bus.imem_req), 16'h0);
      check("full_idpc", bus.id_pc, 16'h0012);
      nxt(); redir = 1'b1; redir_pc = 16'h0100; // cycle 6
      mid(); check("full_req2", 16'(bus.imem_req), 16'h0);
      nxt(); redir = 1'b0; ready = 1'b1;        // cycle 7
      mid();
      check("redir_valid", 16'(bus.id_valid), 16'h0);
      check("redir_addr", bus.imem_addr, 16'h0100);
      check("redir_req", 16'(bus.imem_req), 16'h1);
      nxt(); mid();                             // cycle 8
      check("redir_idpc", bus.id_pc, 16'h0100);
      nxt(); redir = 1'b1; redir_pc = 16'h0005; // cycle 9
      nxt(); redir = 1'b0; ack = 1'b0;          // cycle 10
      mid();
      check("w_addr0", bus.imem_addr, 16'h0005);
      check("w_valid0", 16'(bus.id_valid), 16'h0);
      nxt(); redir = 1'b1; redir_pc = 16'h0200; // cycle 11
      nxt(); redir_pc = 16'h0300;               // cycle 12
      mid(); check("w_addr1", bus.imem_addr, 16'h0005);
      nxt(); redir = 1'b0;                      // cycle 13
      mid(); check("w_addr2", bus.imem_addr, 16'h0005);
      nxt(); nxt();                             // cycles 14, 15
      nxt(); ack = 1'b1;                        // cycle 16
      mid();
      check("w_addr3", bus.imem_addr, 16'h0005);
      check("w_req3", 16'(bus.imem_req), 16'h1);
      nxt(); mid();                             // cycle 17
      check("w_tgt_addr", bus.imem_addr, 16'h0300);
      check("w_tgt_req", 16'(bus.imem_req), 16'h1);
      check("w_tgt_valid", 16'(bus.id_valid), 16'h0);
      nxt(); mid();                             // cycle 18
      check("w_idpc", bus.id_pc, 16'h0300);
      nxt(); redir = 1'b1; redir_pc = 16'hFFFE; // cycle 19
      nxt(); redir = 1'b0;                      // cycle 20
      mid(); check("wrap_a0", bus.imem_addr, 16'hFFFE);
      nxt(); mid(); check("wrap_a1", bus.imem_addr, 16'hFFFF);
      nxt(); mid(); check("wrap_a2", bus.imem_addr, 16'h0000);
      nxt(); ack = 1'b0; ready = 1'b0;          // cycle 23
      mid();
      check("wrap_a3", bus.imem_addr, 16'h0001);
      check("wrap_idpc", bus.id_pc, 16'h0000);
      nxt();                                    // cycle 24: req pending, queue non-empty
      #2 rst = 1'b1;
      #1;
      check("arst_req", 16'(bus.imem_req), 16'h0);
      check("arst_valid", 16'(bus.id_valid), 16'h0);
      check("arst_addr", bus.imem_addr, 16'h0010);
      check("phaseA_left", 16'(exp_q.size()), 16'h0);

      // Phase B: restart with decode stalled, then release
      ack = 1'b1;
      expect_pc(16'h0010); expect_pc(16'h0011); expect_pc(16'h0012); expect_pc(16'h0013);
      nxt(); nxt();
      rst = 1'b0;                               // cycle 0
      nxt(); mid();                             // cycle 1
      check("bp_restart_addr", bus.imem_addr, 16'h0010);
      nxt();                                    // cycle 2
      for (int c = 3; c <= 5; c++) begin
         nxt(); mid();
         check("bp_req", 16'(bus.imem_req), 16'h0);
         check("bp_head", bus.id_pc, 16'h0010);
      end
      nxt(); ready = 1'b1;                      // cycle 6
      nxt(); mid();                             // cycle 7
      check("bp_resume_req", 16'(bus.imem_req), 16'h1);
      check("bp_resume_addr", bus.imem_addr, 16'h0012);
      check("bp_resume_head", bus.id_pc, 16'h0011);
      nxt(); nxt(); nxt(); ready = 1'b0;        // cycle 10
      nxt(); nxt(); mid();
      check("phaseB_left", 16'(exp_q.size()), 16'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
